renkon_linebuf_sched: RTL and testbench

- Sequencer for the renkon line-buffer datapath. Once per feature map it writes the incoming pixel stream into FSIZE circular row buffers.
- For each output row it replays buffer columns with row/column zero-pad flags, so the downstream window shifter forms FSIZE x FSIZE "same"-padded windows.
- Sits between the input DMA stream and the linebuf storage / pad-mask logic of the conv engine.

---
 rtl/renkon_pkg.sv | 18 +
 rtl/renkon_linebuf_padmask.sv | 34 +++
 rtl/renkon_linebuf_sched.sv | 192 +++++++++++++++++++
 tb/tb_renkon_linebuf_sched.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/renkon_pkg.sv
// Shared types and defaults for the renkon line-buffer scheduler and its pad-mask helper.
package renkon_pkg;

    localparam int FSIZE_DEF  = 5;
    localparam int MAXIMG_DEF = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        EMIT = 2'd2,
        DONE = 2'd3
    } linebuf_sched_state_t;

    function automatic int padOf(input int fsize);
        return (fsize - 1) / 2;
    endfunction

endpackage

// File: rtl/renkon_linebuf_padmask.sv
// Combinational zero-pad flags for one window step: which window rows and
// which column fall outside a square H x H image.
module renkon_linebuf_padmask
    import renkon_pkg::*;
#(
    parameter int FSIZE  = FSIZE_DEF,
    parameter int PAD    = padOf(FSIZE),
    parameter int LWIDTH = 6,
    parameter int XWIDTH = 6
) (
    input  logic [LWIDTH-1:0] i_orow,
    input  logic [LWIDTH-1:0] i_h,
    input  logic [XWIDTH-1:0] i_x,
    output logic [FSIZE-1:0]  o_row_pad,
    output logic              o_col_pad
);
    localparam int CWIDTH = ((LWIDTH > XWIDTH) ? LWIDTH : XWIDTH) + 2;

    logic [CWIDTH-1:0] w_h_pad;

    assign w_h_pad = CWIDTH'(i_h) + CWIDTH'(PAD);

    // Window row k is image row orow-PAD+k; compare with PAD added on both sides to stay unsigned.
    always_comb begin
        o_row_pad = '0;
        for (int k = 0; k < FSIZE; k++) begin
            o_row_pad[k] = ((CWIDTH'(i_orow) + CWIDTH'(k)) < CWIDTH'(PAD)) ||
                           ((CWIDTH'(i_orow) + CWIDTH'(k)) >= w_h_pad);
        end
    end

    assign o_col_pad = (CWIDTH'(i_x) < CWIDTH'(PAD)) || (CWIDTH'(i_x) >= w_h_pad);

endmodule

// File: rtl/renkon_linebuf_sched.sv
// Line-buffer sequencer: loads pixel rows into FSIZE circular buffers and replays
// padded columns per output row so the window shifter sees "same"-padded windows.
module renkon_linebuf_sched
    import renkon_pkg::*;
#(
    parameter int FSIZE  = FSIZE_DEF,
    parameter int PAD    = padOf(FSIZE),
    parameter int MAXIMG = MAXIMG_DEF,
    parameter int LWIDTH = $clog2(MAXIMG + 1),
    parameter int RWIDTH = $clog2(FSIZE)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_req,
    input  logic [LWIDTH-1:0] i_img_size,
    output logic              o_ack,
    output logic              o_busy,
    input  logic              i_in_valid,
    output logic              o_in_ready,
    output logic              o_buf_we,
    output logic [FSIZE-1:0]  o_buf_wsel,
    output logic [LWIDTH-1:0] o_buf_waddr,
    input  logic              i_out_ready,
    output logic              o_buf_re,
    output logic [LWIDTH-1:0] o_buf_raddr,
    output logic [RWIDTH-1:0] o_buf_rbase,
    output logic [FSIZE-1:0]  o_row_pad,
    output logic              o_col_pad,
    output logic              o_win_valid,
    output logic              o_out_last
);
    localparam int XWIDTH = $clog2(MAXIMG + 2 * PAD + 1);
    localparam int CWIDTH = ((LWIDTH > XWIDTH) ? LWIDTH : XWIDTH) + 2;
    localparam logic [RWIDTH-1:0] RBASE_INIT = RWIDTH'((FSIZE - PAD) % FSIZE);
    localparam logic [RWIDTH-1:0] PTR_LAST   = RWIDTH'(FSIZE - 1);

    linebuf_sched_state_t r_state, w_next_state;

    logic [LWIDTH-1:0] r_h;
    logic [LWIDTH-1:0] r_wrow;
    logic [LWIDTH-1:0] r_wcol;
    logic [LWIDTH-1:0] r_orow;
    logic [XWIDTH-1:0] r_x;
    logic [RWIDTH-1:0] r_wptr;
    logic [RWIDTH-1:0] r_rbase;

    logic              w_need_load;
    logic              w_accept;
    logic              w_step;
    logic              w_x_last;
    logic              w_orow_last;
    logic              w_wcol_last;
    logic [FSIZE-1:0]  w_row_pad;
    logic              w_col_pad;

    // Rows are loaded only until the one needed by the bottom of the next window is present.
    assign w_need_load = (r_wrow < r_h) &&
                         (CWIDTH'(r_wrow) <= CWIDTH'(r_orow) + CWIDTH'(PAD));
    assign w_accept    = (r_state == LOAD) && w_need_load && i_in_valid;
    assign w_step      = (r_state == EMIT) && i_out_ready;
    assign w_x_last    = CWIDTH'(r_x) == CWIDTH'(r_h) + CWIDTH'(2 * PAD - 1);
    assign w_orow_last = r_orow == (r_h - LWIDTH'(1));
    assign w_wcol_last = r_wcol == (r_h - LWIDTH'(1));

    renkon_linebuf_padmask #(
        .FSIZE  (FSIZE),
        .PAD    (PAD),
        .LWIDTH (LWIDTH),
        .XWIDTH (XWIDTH)
    ) u_padmask (
        .i_orow    (r_orow),
        .i_h       (r_h),
        .i_x       (r_x),
        .o_row_pad (w_row_pad),
        .o_col_pad (w_col_pad)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_h     <= '0;
            r_wrow  <= '0;
            r_wcol  <= '0;
            r_orow  <= '0;
            r_x     <= '0;
            r_wptr  <= '0;
            r_rbase <= RBASE_INIT;
        end else begin
            case (r_state)
                IDLE: begin
                    if (i_req && (i_img_size != '0)) begin
                        r_h <= i_img_size;
                    end
                end
                LOAD: begin
                    if (w_accept) begin
                        if (w_wcol_last) begin
                            r_wcol <= '0;
                            r_wptr <= (r_wptr == PTR_LAST) ? '0 : r_wptr + RWIDTH'(1);
                            r_wrow <= r_wrow + LWIDTH'(1);
                        end else begin
                            r_wcol <= r_wcol + LWIDTH'(1);
                        end
                    end
                end
                EMIT: begin
                    if (w_step) begin
                        if (w_x_last) begin
                            r_x     <= '0;
                            r_orow  <= r_orow + LWIDTH'(1);
                            r_rbase <= (r_rbase == PTR_LAST) ? '0 : r_rbase + RWIDTH'(1);
                        end else begin
                            r_x <= r_x + XWIDTH'(1);
                        end
                    end
                end
                DONE: begin
                    r_wrow  <= '0;
                    r_wcol  <= '0;
                    r_orow  <= '0;
                    r_x     <= '0;
                    r_wptr  <= '0;
                    r_rbase <= RBASE_INIT;
                end
                default: begin
                    r_x <= '0;
                end
            endcase
        end
    end

    always_comb begin
        w_next_state = r_state;
        o_ack        = 1'b0;
        o_busy       = 1'b1;
        o_in_ready   = 1'b0;
        o_buf_wsel   = '0;
        o_buf_waddr  = '0;
        o_buf_re     = 1'b0;
        o_buf_raddr  = '0;
        o_buf_rbase  = '0;
        o_row_pad    = '0;
        o_col_pad    = 1'b0;
        o_win_valid  = 1'b0;
        o_out_last   = 1'b0;
        case (r_state)
            IDLE: begin
                o_busy = 1'b0;
                if (i_req) begin
                    w_next_state = (i_img_size != '0) ? LOAD : DONE;
                end
            end
            LOAD: begin
                o_in_ready  = w_need_load;
                o_buf_wsel  = FSIZE'(1) << r_wptr;
                o_buf_waddr = r_wcol;
                if (!w_need_load) begin
                    w_next_state = EMIT;
                end
            end
            EMIT: begin
                o_buf_re    = 1'b1;
                o_buf_raddr = w_col_pad ? '0 : LWIDTH'(r_x - XWIDTH'(PAD));
                o_buf_rbase = r_rbase;
                o_row_pad   = w_row_pad;
                o_col_pad   = w_col_pad;
                o_win_valid = r_x >= XWIDTH'(2 * PAD);
                o_out_last  = w_orow_last && w_x_last;
                if (w_step && w_x_last) begin
                    w_next_state = w_orow_last ? DONE : LOAD;
                end
            end
            DONE: begin
                o_ack        = 1'b1;
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    assign o_buf_we = o_in_ready & i_in_valid;

endmodule

// File: tb/tb_renkon_linebuf_sched.sv
// Directed bench for renkon_linebuf_sched: an event-list model of the expected
// buffer writes and read steps, compared on every active cycle, plus literal pins.
module tb_renkon_linebuf_sched;

    localparam int FS  = 5;
    localparam int PAD = 2;
    localparam int LW  = 6;
    localparam int RW  = 3;

    typedef struct {
        bit          isRead;
        int          row;
        int          col;
        int          x;
        logic [4:0]  wsel;
        logic [5:0]  waddr;
        logic [5:0]  raddr;
        logic [2:0]  rbase;
        logic [4:0]  rowPad;
        bit          colPad;
        bit          winValid;
        bit          last;
    } ev_t;

    logic          clk;
    logic          rst;
    logic          i_req;
    logic [LW-1:0] i_img_size;
    logic          o_ack;
    logic          o_busy;
    logic          i_in_valid;
    logic          o_in_ready;
    logic          o_buf_we;
    logic [FS-1:0] o_buf_wsel;
    logic [LW-1:0] o_buf_waddr;
    logic          i_out_ready;
    logic          o_buf_re;
    logic [LW-1:0] o_buf_raddr;
    logic [RW-1:0] o_buf_rbase;
    logic [FS-1:0] o_row_pad;
    logic          o_col_pad;
    logic          o_win_valid;
    logic          o_out_last;

    ev_t  evQ[$];
    ev_t  curEv;
    int   evIdx;
    int   total;
    int   bad;
    bit   checkEn;
    bit   stallMode;
    bit   prevAck;
    int   ackCount;
    int   weCount;
    int   stepCount;
    int   winCount;
    int   lastAt;
    time  reqTime;
    time  ackTime;
    logic [4:0] capRowPad[8];
    logic [2:0] capRbase[8];
    logic [4:0] capWsel[8];
    logic [7:0] capColPad;

    renkon_linebuf_sched u_dut (
        .clk         (clk),
        .rst         (rst),
        .i_req       (i_req),
        .i_img_size  (i_img_size),
        .o_ack       (o_ack),
        .o_busy      (o_busy),
        .i_in_valid  (i_in_valid),
        .o_in_ready  (o_in_ready),
        .o_buf_we    (o_buf_we),
        .o_buf_wsel  (o_buf_wsel),
        .o_buf_waddr (o_buf_waddr),
        .i_out_ready (i_out_ready),
        .o_buf_re    (o_buf_re),
        .o_buf_raddr (o_buf_raddr),
        .o_buf_rbase (o_buf_rbase),
        .o_row_pad   (o_row_pad),
        .o_col_pad   (o_col_pad),
        .o_win_valid (o_win_valid),
        .o_out_last  (o_out_last)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
        end
    endtask

    // Expected event order: before each output row, every input row up to orow+PAD
    // must be written; then the H+2*PAD column steps of that row are read.
    function automatic void buildModel(input int h);
        ev_t e;
        int written = 0;
        evQ.delete();
        for (int r = 0; r < h; r++) begin
            while (written < h && written <= r + PAD) begin
                for (int c = 0; c < h; c++) begin
                    e = '{default: 0};
                    e.row   = written;
                    e.col   = c;
                    e.wsel  = 5'(1 << (written % FS));
                    e.waddr = 6'(c);
                    evQ.push_back(e);
                end
                written++;
            end
            for (int x = 0; x < h + 2 * PAD; x++) begin
                e = '{default: 0};
                e.isRead   = 1'b1;
                e.row      = r;
                e.x        = x;
                e.colPad   = (x < PAD) || (x >= h + PAD);
                e.raddr    = e.colPad ? 6'd0 : 6'(x - PAD);
                e.rbase    = 3'((((r - PAD) % FS) + FS) % FS);
                for (int k = 0; k < FS; k++) begin
                    e.rowPad[k] = (r - PAD + k < 0) || (r - PAD + k >= h);
                end
                e.winValid = (x >= 2 * PAD);
                e.last     = (r == h - 1) && (x == h + 2 * PAD - 1);
                evQ.push_back(e);
            end
        end
    endfunction

    task automatic clearObs();
        evIdx     = 0;
        ackCount  = 0;
        prevAck   = 1'b0;
        weCount   = 0;
        stepCount = 0;
        winCount  = 0;
        lastAt    = -1;
        ackTime   = 0;
        capColPad = '0;
        for (int i = 0; i < 8; i++) begin
            capRowPad[i] = '0;
            capRbase[i]  = '0;
            capWsel[i]   = '0;
        end
    endtask

    always @(negedge clk) begin
        if (checkEn && !rst) begin
            if (prevAck) checkOutput("busy_drop_after_ack", int'(o_busy), 0);
            prevAck = o_ack;
            if (o_ack) begin
                ackCount++;
                if (ackTime == 0) ackTime = $time;
                checkOutput("busy_during_ack", int'(o_busy), 1);
            end
            if (o_buf_we || o_buf_re) begin
                checkOutput("we_re_overlap", int'(o_buf_we && o_buf_re), 0);
                checkOutput("busy_active", int'(o_busy), 1);
            end
            if (o_buf_we) begin
                weCount++;
                checkOutput("in_ready_on_we", int'(o_in_ready), 1);
                if (evIdx >= evQ.size()) begin
                    checkOutput("extra_write", evIdx, evQ.size());
                end else begin
                    curEv = evQ[evIdx];
                    checkOutput("write_expected", int'(curEv.isRead), 0);
                    checkOutput("buf_wsel", int'(o_buf_wsel), int'(curEv.wsel));
                    checkOutput("buf_waddr", int'(o_buf_waddr), int'(curEv.waddr));
                    if (curEv.col == 0 && curEv.row < 8) capWsel[curEv.row] = o_buf_wsel;
                    evIdx++;
                end
            end else if (o_buf_re) begin
                if (evIdx >= evQ.size()) begin
                    checkOutput("extra_read", evIdx, evQ.size());
                end else begin
                    curEv = evQ[evIdx];
                    checkOutput("read_expected", int'(curEv.isRead), 1);
                    checkOutput("buf_raddr", int'(o_buf_raddr), int'(curEv.raddr));
                    checkOutput("buf_rbase", int'(o_buf_rbase), int'(curEv.rbase));
                    checkOutput("row_pad", int'(o_row_pad), int'(curEv.rowPad));
                    checkOutput("col_pad", int'(o_col_pad), int'(curEv.colPad));
                    checkOutput("win_valid", int'(o_win_valid), int'(curEv.winValid));
                    checkOutput("out_last", int'(o_out_last), int'(curEv.last));
                    if (i_out_ready) begin
                        stepCount++;
                        if (o_win_valid) winCount++;
                        if (o_out_last) lastAt = stepCount;
                        if (curEv.x == 0 && curEv.row < 8) begin
                            capRowPad[curEv.row] = o_row_pad;
                            capRbase[curEv.row]  = o_buf_rbase;
                        end
                        if (curEv.row == 0 && curEv.x < 8) capColPad[curEv.x] = o_col_pad;
                        evIdx++;
                    end
                end
            end
        end
    end

    initial begin
        i_in_valid  = 1'b0;
        i_out_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (stallMode) begin
                i_in_valid  = 1'($urandom_range(0, 1));
                i_out_ready = 1'($urandom_range(0, 1));
            end else begin
                i_in_valid  = 1'b1;
                i_out_ready = 1'b1;
            end
        end
    end

    task automatic checkAllZero(input string name);
        checkOutput(name, int'(|{o_ack, o_busy, o_in_ready, o_buf_we, o_buf_wsel, o_buf_waddr,
                                 o_buf_re, o_buf_raddr, o_buf_rbase, o_row_pad, o_col_pad,
                                 o_win_valid, o_out_last}), 0);
    endtask

    task automatic issueReq(input int h);
        buildModel(h);
        clearObs();
        @(posedge clk);
        #1;
        i_req      = 1'b1;
        i_img_size = LW'(h);
        reqTime    = $time;
        @(posedge clk);
        #1;
        i_req = 1'b0;
    endtask

    task automatic waitAck();
        int cyc = 0;
        while (ackCount == 0 && cyc < 3000) begin
            @(posedge clk);
            cyc++;
        end
        checkOutput("ack_timeout", int'(ackCount > 0), 1);
    endtask

    task automatic applyStimulus(input int h, input bit stall, input bit pokeReq);
        stallMode = stall;
        issueReq(h);
        if (pokeReq) begin
            repeat (4) @(posedge clk);
            #1;
            i_req      = 1'b1;
            i_img_size = LW'(1);
            @(posedge clk);
            #1;
            i_req = 1'b0;
        end
        waitAck();
        repeat (6) @(posedge clk);
        checkOutput("events_consumed", evIdx, evQ.size());
        checkOutput("ack_count", ackCount, 1);
    endtask

    initial begin
        int  cyc;
        bit  found;
        total      = 0;
        bad        = 0;
        checkEn    = 1'b0;
        stallMode  = 1'b0;
        rst        = 1'b1;
        i_req      = 1'b0;
        i_img_size = '0;
        clearObs();
        repeat (2) @(negedge clk);
        checkAllZero("reset_outputs");
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("idle_outputs");
        checkEn = 1'b1;

        $display("[TB] 4x4 map, no stalls");
        applyStimulus(4, 1'b0, 1'b0);
        checkOutput("h4_pixels_written", weCount, 16);
        checkOutput("h4_read_steps", stepCount, 32);
        checkOutput("h4_win_valid_steps", winCount, 16);
        checkOutput("h4_out_last_step", lastAt, 32);
        checkOutput("h4_orow0_row_pad", int'(capRowPad[0]), 5'b00011);
        checkOutput("h4_orow0_rbase", int'(capRbase[0]), 3);
        checkOutput("h4_orow2_row_pad", int'(capRowPad[2]), 5'b10000);
        checkOutput("h4_orow2_rbase", int'(capRbase[2]), 0);
        checkOutput("h4_orow3_row_pad", int'(capRowPad[3]), 5'b11000);
        checkOutput("h4_orow0_col_pad", int'(capColPad), 8'b1100_0011);

        $display("[TB] 1x1 map");
        applyStimulus(1, 1'b0, 1'b0);
        checkOutput("h1_pixels_written", weCount, 1);
        checkOutput("h1_read_steps", stepCount, 5);
        checkOutput("h1_row_pad", int'(capRowPad[0]), 5'b11011);
        checkOutput("h1_win_valid_steps", winCount, 1);
        checkOutput("h1_out_last_step", lastAt, 5);

        $display("[TB] 4x4 map, random stalls");
        applyStimulus(4, 1'b1, 1'b0);
        checkOutput("stall_read_steps", stepCount, 32);
        checkOutput("stall_wsel_rows", int'({capWsel[3], capWsel[2], capWsel[1], capWsel[0]}),
                    20'b01000_00100_00010_00001);

        $display("[TB] req while busy");
        applyStimulus(4, 1'b0, 1'b1);
        checkOutput("busy_req_pixels", weCount, 16);

        $display("[TB] zero-size map");
        applyStimulus(0, 1'b0, 1'b0);
        checkOutput("zero_no_writes", weCount, 0);
        checkOutput("zero_no_reads", stepCount, 0);
        checkOutput("zero_ack_latency_le2", int'((ackTime - reqTime) / 10 <= 2), 1);

        $display("[TB] reset in the middle of orow 1");
        stallMode = 1'b0;
        issueReq(4);
        found = 1'b0;
        cyc   = 0;
        while (!found && cyc < 500) begin
            @(negedge clk);
            found = o_buf_re && (o_buf_rbase == 3'd4);
            cyc++;
        end
        checkOutput("midmap_reach_orow1", int'(found), 1);
        checkEn = 1'b0;
        rst     = 1'b1;
        #1;
        checkAllZero("midmap_reset_async");
        @(negedge clk);
        checkAllZero("midmap_reset_held");
        rst = 1'b0;
        @(negedge clk);
        checkAllZero("midmap_after_release");
        checkEn = 1'b1;
        applyStimulus(4, 1'b0, 1'b0);
        checkOutput("post_reset_pixels", weCount, 16);
        checkOutput("post_reset_steps", stepCount, 32);

        $display("[TB] test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
